// File: rtl/demux_sched_pkg.sv
// Shared types and helpers for the demux scheduler: FSM state encoding and sel->lane mapping.
package demux_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Lane numbering runs opposite to sel: sel 0 drives lane 3.
  function automatic logic [1:0] lane_of_sel(input logic [1:0] s);
    return 2'd3 - s;
  endfunction

endpackage

// File: rtl/demux_sched_pick.sv
// Combinational round-robin picker: next sel after the current one whose lane is enabled,
// or the current sel when no other enabled lane exists.
module demux_sched_pick
  import demux_sched_pkg::*;
(
  input  logic [1:0] sel,
  input  logic [3:0] en,
  output logic [1:0] next_sel
);

  logic [1:0] cand;

  // Scan farthest-first so the nearest enabled candidate wins.
  always_comb begin
    next_sel = sel;
    cand     = sel;
    for (int k = 3; k >= 1; k--) begin
      cand = sel + 2'(k);
      if (en[lane_of_sel(cand)]) next_sel = cand;
    end
  end

endmodule

// File: rtl/demux_sched.sv
// One-entry demultiplexer scheduling items round-robin over four lanes (lane = 3 - sel).
// Build with DEMUX_SCHED_SKIP_EN to let a stalled item hop to the next enabled lane.
module demux_sched
  import demux_sched_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  input  logic [3:0]         en,
  input  logic [3:0]         out_ready,
  output logic [3:0]         out_valid,
  output logic [4*WIDTH-1:0] out_data,
  output logic [1:0]         sel,
  output state_t             state
);

  // Handshake: a beat moves on an edge where valid and ready are both high;
  // valid never waits on ready, and an offered item stays stable until taken.

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d, pick_sel, lane;
  logic [WIDTH-1:0] held_q, held_d;
  logic             transfer, accept;

  demux_sched_pick u_pick (
    .sel      (sel_q),
    .en       (en),
    .next_sel (pick_sel)
  );

  assign lane     = lane_of_sel(sel_q);
  assign transfer = (state_q == HOLD) && out_ready[lane];
  assign in_ready = !rst && (((state_q == IDLE) && (en != 4'b0000)) || transfer);
  assign accept   = in_valid && in_ready;
  assign sel      = sel_q;
  assign state    = state_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    held_d  = held_q;
    case (state_q)
      IDLE: begin
        // An idle sel parked on a disabled lane is moved before the item lands.
        if ((en != 4'b0000) && !en[lane]) sel_d = pick_sel;
        if (accept) begin
          state_d = HOLD;
          held_d  = in_data;
        end
      end
      HOLD: begin
        if (transfer) begin
          sel_d   = pick_sel;
          state_d = accept ? HOLD : IDLE;
          if (accept) held_d = in_data;
        end
`ifdef DEMUX_SCHED_SKIP_EN
        else begin
          sel_d = pick_sel;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'b00;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    out_valid = 4'b0000;
    out_data  = '0;
    if (state_q == HOLD) begin
      out_valid[lane]                      = 1'b1;
      out_data[int'(lane)*WIDTH +: WIDTH] = held_q;
    end
  end

endmodule

// File: tb/tb_demux_sched.sv
// Directed bench for demux_sched (WIDTH=8): throughput, masked round-robin, stall,
// empty-mask wakeup, reset mid-hold and enable change during hold.
module tb_demux_sched;
  import demux_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [3:0]  en;
  logic [3:0]  out_ready;
  logic [3:0]  out_valid;
  logic [31:0] out_data;
  logic [1:0]  sel;
  state_t      state;

  int passed = 0;
  int total  = 0;

  demux_sched #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .en        (en),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] v, input logic [31:0] d,
                         input logic [1:0] s);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_sel"}, 32'(sel), 32'(s));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A; en = 4'b1111; out_ready = 4'b1111;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk_out("rst", 4'b0000, 32'h0, 2'b00);
    chk("rst_state", 32'(state), 32'(IDLE));

    // Back-to-back over all lanes, one item per cycle.
    rst = 1'b0; in_data = 8'hA1;
    #1 chk("tp_in_ready0", 32'(in_ready), 32'd1);
    tick(); in_data = 8'hA2;
    chk_out("tp1", 4'b1000, 32'hA100_0000, 2'b00);
    chk("tp1_in_ready", 32'(in_ready), 32'd1);
    tick(); in_data = 8'hA3;
    chk_out("tp2", 4'b0100, 32'h00A2_0000, 2'b01);
    tick(); in_data = 8'hA4;
    chk_out("tp3", 4'b0010, 32'h0000_A300, 2'b10);
    tick(); in_valid = 1'b0;
    chk_out("tp4", 4'b0001, 32'h0000_00A4, 2'b11);
    tick();
    chk_out("tp_done", 4'b0000, 32'h0, 2'b00);
    chk("tp_state", 32'(state), 32'(IDLE));

    // Mask 0101: lanes 2 and 0 alternate.
    en = 4'b0101; in_valid = 1'b1; in_data = 8'hB1;
    tick(); in_data = 8'hB2;
    chk_out("m1", 4'b0100, 32'h00B1_0000, 2'b01);
    tick(); in_data = 8'hB3;
    chk_out("m2", 4'b0001, 32'h0000_00B2, 2'b11);
    tick(); in_data = 8'hB4;
    chk_out("m3", 4'b0100, 32'h00B3_0000, 2'b01);
    tick(); in_valid = 1'b0;
    chk_out("m4", 4'b0001, 32'h0000_00B4, 2'b11);
    tick();
    chk_out("m_done", 4'b0000, 32'h0, 2'b01);

    // Lane 3 stalls with an item held at sel 00.
    rst = 1'b1; tick(); rst = 1'b0;
    chk("stall_rst_sel", 32'(sel), 32'd0);
    en = 4'b1111; out_ready = 4'b0111; in_valid = 1'b1; in_data = 8'hC1;
    tick(); in_data = 8'hC2;
    chk_out("stall0", 4'b1000, 32'hC100_0000, 2'b00);
    chk("stall0_in_ready", 32'(in_ready), 32'd0);
`ifdef DEMUX_SCHED_SKIP_EN
    out_ready = 4'b0000;
    tick();
    chk_out("skip1", 4'b0100, 32'h00C1_0000, 2'b01);
    out_ready = 4'b1111;
`else
    for (int i = 1; i < 5; i++) begin
      tick();
      chk_out("stall", 4'b1000, 32'hC100_0000, 2'b00);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 4'b1111; in_valid = 1'b0;
    tick();
    chk_out("stall_done", 4'b0000, 32'h0, 2'b01);
`endif

    // Reset asserted while an item is held on sel 01.
    in_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    en = 4'b1111; out_ready = 4'b0000; in_valid = 1'b1; in_data = 8'hD1;
    tick(); out_ready = 4'b1111; in_data = 8'hD2;
    chk_out("r_hold1", 4'b1000, 32'hD100_0000, 2'b00);
    tick(); out_ready = 4'b0000;
    chk_out("r_hold2", 4'b0100, 32'h00D2_0000, 2'b01);
    rst = 1'b1;
    #1 chk("r_in_ready_rst", 32'(in_ready), 32'd0);
    tick();
    chk_out("r_after", 4'b0000, 32'h0, 2'b00);
    chk("r_in_ready", 32'(in_ready), 32'd0);
    chk("r_state", 32'(state), 32'(IDLE));

    // Empty mask blocks input; enabling lane 1 wakes it.
    rst = 1'b0; en = 4'b0000; out_ready = 4'b1111; in_valid = 1'b1; in_data = 8'hE1;
    #1 chk("e0_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk_out("e0", 4'b0000, 32'h0, 2'b00);
    chk("e0_in_ready2", 32'(in_ready), 32'd0);
    en = 4'b0010;
    #1 chk("e1_in_ready", 32'(in_ready), 32'd1);
    tick(); in_valid = 1'b0;
    chk_out("e1", 4'b0010, 32'h0000_E100, 2'b10);
    tick();
    chk_out("e_done", 4'b0000, 32'h0, 2'b10);

    // Enable change while holding: item stays, next pick uses new mask.
    en = 4'b1111; out_ready = 4'b0000; in_valid = 1'b1; in_data = 8'hF1;
    tick(); in_valid = 1'b0; en = 4'b1000;
    #1 chk_out("en_hold", 4'b0010, 32'h0000_F100, 2'b10);
    out_ready = 4'b1111;
    tick();
    chk_out("en_done", 4'b0000, 32'h0, 2'b00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/demux_sched.md
DEMUX_SCHED -- requirements
Module: demux_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 1, giving the data width per item.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  upstream item present.
REQ-005 SHALL have port in_data  input  WIDTH  upstream item.
REQ-006 SHALL have port in_ready  output  1  item accepted on this edge when in_valid is also high.
REQ-007 SHALL have port en  input  4  lane enable mask, indexed by lane y-index.
REQ-008 SHALL have port out_ready  input  4  per-lane downstream ready.
REQ-009 SHALL have port out_valid  output  4  one-hot per-lane valid; all zero when no item is held.
REQ-010 SHALL have port out_data  output  4*WIDTH  per-lane data; non-selected lanes are driven to zero.
REQ-011 SHALL have port sel  output  2  current demux select.

Function
REQ-012 SHALL map sel to lane as: 00->lane 3, 01->lane 2, 10->lane 1, 11->lane 0 (lane = 3 - sel).
REQ-013 SHALL implement FSM states IDLE (buffer empty) and HOLD (one item buffered).
REQ-014 SHALL assert in_ready when rst=0 and either (IDLE and en!=0) or (HOLD and the held item transfers this cycle).
REQ-015 SHALL, on in_valid&&in_ready, register in_data and go to or stay in HOLD; out_valid SHALL rise on the next cycle (latency 1).
REQ-016 SHALL, in HOLD, drive out_valid[3-sel]=1 and out_data lane (3-sel) = held item.
REQ-017 SHALL treat a transfer as HOLD && out_ready[3-sel] at the clock edge.
REQ-018 SHALL, on transfer, advance sel to the next sel value in cyclic order 0,1,2,3,0... whose lane is enabled in en; if only the current lane is enabled, sel SHALL remain unchanged.
REQ-019 SHALL return to IDLE after a transfer without a simultaneous accept, and stay in HOLD with the new item on the advanced sel when both occur (one item per cycle throughput).
REQ-020 SHALL keep a held item on its lane when en changes; en SHALL affect only the next selection.
REQ-021 SHALL keep in_ready=0 in IDLE while en=0, and SHALL leave sel unchanged.
REQ-022 SHALL, when en becomes non-zero while in IDLE and lane (3-sel) is disabled, move sel to the next enabled lane before accepting.
REQ-023 SHALL hold out_data and sel stable while out_valid is high and no transfer occurs.

Reset
REQ-024 SHALL set, while rst=1 at an edge: state=IDLE, sel=00, out_valid=0000, out_data=0, held item=0, and in_ready=0.
REQ-025 SHALL discard a held item when rst is asserted mid-HOLD, with no transfer reported on that edge.

Configuration
REQ-026 SHALL honour macro DEMUX_SCHED_SKIP_EN: when defined, in HOLD with out_ready[3-sel]=0 for a cycle, sel SHALL advance to the next enabled lane and the held item SHALL be offered there next cycle.
REQ-027 SHALL, without DEMUX_SCHED_SKIP_EN, wait on the current lane indefinitely (strict round-robin).

Structure
REQ-028 SHALL place the state enum and a lane_of_sel constant/function in package demux_sched_pkg.
REQ-029 SHALL implement next-enabled-sel selection in combinational sub-module demux_sched_pick (inputs sel, en; output next sel).

Verification
REQ-030 SHALL cover: en=1111, out_ready=1111, items 1,0,1,1 back-to-back -> out_valid 1000,0100,0010,0001 on consecutive cycles, one per cycle.
REQ-031 SHALL cover: en=0101, 4 items -> lanes 2,0,2,0 served; sel sequence 01,11,01,11.
REQ-032 SHALL cover: out_ready[3]=0 for 5 cycles with an item held at sel=00 -> without SKIP_EN, out_valid=1000 held 5 cycles and in_ready=0; with SKIP_EN, item moves to lane 2 after 1 cycle.
REQ-033 SHALL cover: en=0000 with in_valid=1 -> in_ready=0, out_valid=0000; set en=0010 -> sel becomes 10 and the item is accepted, then delivered on lane 1.
REQ-034 SHALL cover: rst pulsed during HOLD -> next cycle out_valid=0000, sel=00, in_ready=0 while rst=1.
